// File: rtl/inv_round_ctrl_if.sv
// rtl/inv_round_ctrl_if.sv - block buffer, key storage and round datapath signals for inv_round_ctrl
interface inv_round_ctrl_if #(parameter int CNT_W = 4);
   logic             in_valid;
   logic             in_ready;
   logic [127:0]     cipher_in;
   logic             key_req;
   logic [CNT_W-1:0] key_idx;
   logic             key_ack;
   logic [127:0]     round_key;
   logic [127:0]     dp_state;
   logic [CNT_W-1:0] dp_count;
   logic [127:0]     dp_key;
   logic [127:0]     dp_result;
   logic             out_valid;
   logic             out_ready;
   logic [127:0]     plain_out;
   logic             abort;
   logic             busy;

   modport master (
      input  in_valid, cipher_in, key_ack, round_key, dp_result, out_ready, abort,
      output in_ready, key_req, key_idx, dp_state, dp_count, dp_key, out_valid, plain_out, busy
   );

   modport slave (
      output in_valid, cipher_in, key_ack, round_key, dp_result, out_ready, abort,
      input  in_ready, key_req, key_idx, dp_state, dp_count, dp_key, out_valid, plain_out, busy
   );
endinterface

// File: rtl/inv_round_ctrl.sv
// rtl/inv_round_ctrl.sv - sequences one block through the AES inverse rounds
// Holds the state register, fetches round keys top-down and drives the round count.
module inv_round_ctrl #(
   parameter int NUM_ROUNDS = 10,
   parameter int CNT_W      = 4
) (
   input logic             clk,
   input logic             n_rst,
   inv_round_ctrl_if.master bus
);
   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT_KEY,
      S_ROUND_KEY,
      S_ROUND_EXEC,
      S_OUT_HOLD
   } fsm_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_ROUNDS - 1);
   localparam logic [CNT_W-1:0] TOP_IDX  = CNT_W'(NUM_ROUNDS);

   fsm_t             r_fsm;
   logic [127:0]     r_state;
   logic [127:0]     r_key;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_key_idx;
   logic             r_key_req;
   logic             r_out_valid;
   logic             r_in_ready;
   logic             r_busy;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_fsm       <= S_IDLE;
         r_state     <= '0;
         r_key       <= '0;
         r_count     <= '0;
         r_key_idx   <= '0;
         r_key_req   <= 1'b0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
         r_busy      <= 1'b0;
      end else if (bus.abort) begin
         // state and key registers are kept so the datapath inputs stay quiet
         r_fsm       <= S_IDLE;
         r_count     <= '0;
         r_key_idx   <= '0;
         r_key_req   <= 1'b0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
         r_busy      <= 1'b0;
      end else begin
         case (r_fsm)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_state    <= bus.cipher_in;
                  r_count    <= '0;
                  r_key_req  <= 1'b1;
                  r_key_idx  <= TOP_IDX;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_fsm      <= S_INIT_KEY;
               end
            end
            S_INIT_KEY: begin
               if (bus.key_ack) begin
                  r_state   <= r_state ^ bus.round_key;
                  r_key_idx <= LAST_CNT - r_count;
                  r_fsm     <= S_ROUND_KEY;
               end
            end
            S_ROUND_KEY: begin
               if (bus.key_ack) begin
                  r_key     <= bus.round_key;
                  r_key_req <= 1'b0;
                  r_key_idx <= '0;
                  r_fsm     <= S_ROUND_EXEC;
               end
            end
            S_ROUND_EXEC: begin
               r_state <= bus.dp_result;
               if (r_count == LAST_CNT) begin
                  r_out_valid <= 1'b1;
                  r_fsm       <= S_OUT_HOLD;
               end else begin
                  // next request is for the key one below the current round's
                  r_count   <= r_count + CNT_W'(1);
                  r_key_idx <= LAST_CNT - r_count - CNT_W'(1);
                  r_key_req <= 1'b1;
                  r_fsm     <= S_ROUND_KEY;
               end
            end
            S_OUT_HOLD: begin
               if (bus.out_ready) begin
                  r_count     <= '0;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
                  r_fsm       <= S_IDLE;
               end
            end
            default: begin
               r_fsm <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.key_req   = r_key_req;
   assign bus.key_idx   = r_key_idx;
   assign bus.dp_state  = r_state;
   assign bus.dp_count  = r_count;
   assign bus.dp_key    = r_key;
   assign bus.out_valid = r_out_valid;
   assign bus.plain_out = r_state;
   assign bus.busy      = r_busy;
endmodule

// File: tb/tb_inv_round_ctrl.sv
// tb/tb_inv_round_ctrl.sv - scoreboard bench for inv_round_ctrl with an AES round datapath and key store
module tb_inv_round_ctrl;
   localparam int NR = 10;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   always #5 clk = ~clk;

   inv_round_ctrl_if #(.CNT_W(CW)) ifc ();
   inv_round_ctrl #(.NUM_ROUNDS(NR), .CNT_W(CW)) dut (.clk(clk), .n_rst(n_rst), .bus(ifc));

   typedef struct {
      logic [127:0] pt;
      int           acc_cyc;
      int           acc_wait;
   } exp_t;

   exp_t         sb[$];
   logic [3:0]   idx_log[$];
   logic [7:0]   sbox[256];
   logic [7:0]   isbox[256];
   logic [127:0] rk_tab[11];
   int n_chk = 0, n_pass = 0;
   int cyc = 0;
   int max_delay = 0, total_wait = 0;
   bit stall = 0, spurious = 0;
   int stall_cnt = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, t;
      p = 8'h00;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = xt(t);
      end
      return p;
   endfunction

   task automatic init_tables();
      logic [7:0] inv, t, s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         if (x != 0)
            for (int y = 1; y < 256; y++)
               if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         t = inv;
         s = inv;
         for (int k = 0; k < 4; k++) begin
            t = {t[6:0], t[7]};
            s = s ^ t;
         end
         s = s ^ 8'h63;
         sbox[x] = s;
         isbox[s] = 8'(x);
      end
   endtask

   task automatic load_key(input logic [127:0] k);
      logic [31:0] w[44];
      logic [31:0] t;
      logic [7:0]  rcon;
      rcon = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
            rcon = xt(rcon);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // Reference: forward cipher, so expected plaintext never comes from the inverse path.
   function automatic logic [127:0] aes_enc(input logic [127:0] pt);
      logic [7:0]   a[16], o[16];
      logic [127:0] s;
      s = pt ^ rk_tab[0];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) a[i] = sbox[s[127-8*i -: 8]];
         for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) o[4*c+w] = a[4*((c+w)%4)+w];
         for (int c = 0; c < 4; c++) begin
            if (r < 10) begin
               a[4*c]   = xt(o[4*c]) ^ xt(o[4*c+1]) ^ o[4*c+1] ^ o[4*c+2] ^ o[4*c+3];
               a[4*c+1] = o[4*c] ^ xt(o[4*c+1]) ^ xt(o[4*c+2]) ^ o[4*c+2] ^ o[4*c+3];
               a[4*c+2] = o[4*c] ^ o[4*c+1] ^ xt(o[4*c+2]) ^ xt(o[4*c+3]) ^ o[4*c+3];
               a[4*c+3] = xt(o[4*c]) ^ o[4*c] ^ o[4*c+1] ^ o[4*c+2] ^ xt(o[4*c+3]);
            end else begin
               for (int w = 0; w < 4; w++) a[4*c+w] = o[4*c+w];
            end
         end
         for (int i = 0; i < 16; i++) s[127-8*i -: 8] = a[i];
         s = s ^ rk_tab[r];
      end
      return s;
   endfunction

   function automatic logic [127:0] inv_round(input logic [127:0] st, input logic [127:0] key,
                                              input logic [3:0] cnt);
      logic [7:0]   a[16], o[16];
      logic [127:0] t;
      for (int i = 0; i < 16; i++) a[i] = st[127-8*i -: 8];
      for (int c = 0; c < 4; c++)
         for (int w = 0; w < 4; w++) o[4*((c+w)%4)+w] = isbox[a[4*c+w]];
      for (int i = 0; i < 16; i++) t[127-8*i -: 8] = o[i];
      t = t ^ key;
      if (cnt != 4'(NR - 1)) begin
         for (int i = 0; i < 16; i++) a[i] = t[127-8*i -: 8];
         for (int c = 0; c < 4; c++) begin
            o[4*c]   = gmul(a[4*c],8'h0e) ^ gmul(a[4*c+1],8'h0b) ^ gmul(a[4*c+2],8'h0d) ^ gmul(a[4*c+3],8'h09);
            o[4*c+1] = gmul(a[4*c],8'h09) ^ gmul(a[4*c+1],8'h0e) ^ gmul(a[4*c+2],8'h0b) ^ gmul(a[4*c+3],8'h0d);
            o[4*c+2] = gmul(a[4*c],8'h0d) ^ gmul(a[4*c+1],8'h09) ^ gmul(a[4*c+2],8'h0e) ^ gmul(a[4*c+3],8'h0b);
            o[4*c+3] = gmul(a[4*c],8'h0b) ^ gmul(a[4*c+1],8'h0d) ^ gmul(a[4*c+2],8'h09) ^ gmul(a[4*c+3],8'h0e);
         end
         for (int i = 0; i < 16; i++) t[127-8*i -: 8] = o[i];
      end
      return t;
   endfunction

   assign ifc.dp_result = inv_round(ifc.dp_state, ifc.dp_key, ifc.dp_count);

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Key store: answers each request after a random wait, logs indices in order served.
   initial begin
      int  wait_cnt, delay_tgt;
      bit  ack;
      wait_cnt = 0;
      delay_tgt = 0;
      ifc.key_ack = 1'b0;
      ifc.round_key = '0;
      forever begin
         @(negedge clk);
         ack = 1'b0;
         if (ifc.key_req && wait_cnt >= delay_tgt && !(stall && int'(ifc.dp_count) == stall_cnt))
            ack = 1'b1;
         if (ifc.key_req && !ack) begin
            wait_cnt++;
            total_wait++;
         end
         if (ack) begin
            idx_log.push_back(ifc.key_idx);
            wait_cnt = 0;
            delay_tgt = $urandom_range(max_delay, 0);
         end
         ifc.key_ack = ack | spurious;
         ifc.round_key = (ifc.key_idx <= 4'(NR)) ? rk_tab[ifc.key_idx] : {4{$urandom}};
      end
   end

   // Monitor: latency on out_valid rise, hold stability, plaintext on handshake.
   initial begin
      logic         prev_ov;
      logic [127:0] prev_pt;
      exp_t         e;
      prev_ov = 1'b0;
      prev_pt = '0;
      forever begin
         @(negedge clk);
         #1;
         if (!n_rst) begin
            prev_ov = 1'b0;
            continue;
         end
         if (ifc.out_valid) begin
            check("in_ready_in_hold", ifc.in_ready, 0);
            if (!prev_ov) begin
               check("output_expected", sb.size() != 0, 1);
               if (sb.size() != 0)
                  check("latency", cyc - sb[0].acc_cyc, 22 + total_wait - sb[0].acc_wait);
            end else begin
               check("hold_stable", ifc.plain_out, prev_pt);
            end
            if (ifc.out_ready && sb.size() != 0) begin
               e = sb.pop_front();
               check("plaintext", ifc.plain_out, e.pt);
            end
         end
         prev_ov = ifc.out_valid;
         prev_pt = ifc.plain_out;
      end
   end

   task automatic send_block(input logic [127:0] ct, input logic [127:0] pt);
      int t;
      bit acc;
      t = 0;
      acc = 1'b0;
      while (!acc && t < 500) begin
         @(negedge clk);
         ifc.in_valid = 1'b1;
         ifc.cipher_in = ct;
         if (ifc.in_ready) begin
            sb.push_back('{pt: pt, acc_cyc: cyc, acc_wait: total_wait});
            acc = 1'b1;
         end
         t++;
      end
      @(negedge clk);
      ifc.in_valid = 1'b0;
      check("accept_timeout", acc, 1);
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while ((sb.size() != 0 || ifc.busy) && t < 500) begin
         @(negedge clk);
         t++;
      end
      check("done_timeout", t < 500, 1);
   endtask

   task automatic wait_for(input int what);
      int t;
      bit hit;
      t = 0;
      hit = 1'b0;
      while (!hit && t < 500) begin
         @(negedge clk);
         case (what)
            0: hit = ifc.out_valid;
            1: hit = ifc.key_req && ifc.dp_count == 4'd4;
            default: hit = ifc.busy && !ifc.key_req && !ifc.out_valid && ifc.dp_count == 4'd5;
         endcase
         t++;
      end
      check("event_timeout", hit, 1);
   endtask

   initial begin
      logic [127:0] k, p, st;
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      logic [127:0] k, p, st;
      init_tables();
      ifc.in_valid = 1'b0;
      ifc.cipher_in = '0;
      ifc.out_ready = 1'b1;
      ifc.abort = 1'b0;
      load_key(128'h000102030405060708090a0b0c0d0e0f);

      repeat (3) @(negedge clk);
      check("rst_in_ready", ifc.in_ready, 1);
      check("rst_busy", ifc.busy, 0);
      check("rst_key_req", ifc.key_req, 0);
      check("rst_out_valid", ifc.out_valid, 0);
      check("rst_count", ifc.dp_count, 0);
      check("rst_key_idx", ifc.key_idx, 0);
      check("rst_state", ifc.plain_out, 0);
      check("rst_key", ifc.dp_key, 0);
      n_rst = 1'b1;

      // FIPS-197 C.1 with key_ack in the request cycle
      idx_log.delete();
      max_delay = 0;
      send_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff);
      wait_done();
      check("key_idx_count", idx_log.size(), 11);
      for (int i = 0; i < idx_log.size() && i < 11; i++)
         check($sformatf("key_idx_order%0d", i), idx_log[i], 10 - i);

      // random keys and blocks with 0-3 cycle key waits
      max_delay = 3;
      for (int b = 0; b < 6; b++) begin
         if (b % 3 == 0) begin
            wait_done();
            k = {$urandom, $urandom, $urandom, $urandom};
            load_key(k);
         end
         p = {$urandom, $urandom, $urandom, $urandom};
         send_block(aes_enc(p), p);
      end
      wait_done();

      // backpressure: out_ready low, next block offered meanwhile
      max_delay = 1;
      ifc.out_ready = 1'b0;
      p = {$urandom, $urandom, $urandom, $urandom};
      send_block(aes_enc(p), p);
      wait_for(0);
      p = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         ifc.in_valid = 1'b1;
         ifc.cipher_in = aes_enc(p);
         check("bp_in_ready", ifc.in_ready, 0);
         check("bp_out_valid", ifc.out_valid, 1);
      end
      ifc.out_ready = 1'b1;
      send_block(aes_enc(p), p);
      wait_done();

      // abort while waiting for the round-4 key
      max_delay = 0;
      stall_cnt = 4;
      stall = 1'b1;
      p = {$urandom, $urandom, $urandom, $urandom};
      send_block(aes_enc(p), p);
      wait_for(1);
      st = ifc.dp_state;
      ifc.abort = 1'b1;
      @(negedge clk);
      ifc.abort = 1'b0;
      sb.delete();
      stall = 1'b0;
      check("abort_in_ready", ifc.in_ready, 1);
      check("abort_key_req", ifc.key_req, 0);
      check("abort_busy", ifc.busy, 0);
      check("abort_out_valid", ifc.out_valid, 0);
      check("abort_count", ifc.dp_count, 0);
      check("abort_key_idx", ifc.key_idx, 0);
      check("abort_state_kept", ifc.dp_state, st);
      p = {$urandom, $urandom, $urandom, $urandom};
      send_block(aes_enc(p), p);
      wait_done();

      // asynchronous reset during a round execute cycle
      max_delay = 2;
      p = {$urandom, $urandom, $urandom, $urandom};
      send_block(aes_enc(p), p);
      wait_for(2);
      #3;
      n_rst = 1'b0;
      #1;
      sb.delete();
      check("arst_in_ready", ifc.in_ready, 1);
      check("arst_busy", ifc.busy, 0);
      check("arst_key_req", ifc.key_req, 0);
      check("arst_out_valid", ifc.out_valid, 0);
      check("arst_count", ifc.dp_count, 0);
      check("arst_state", ifc.dp_state, 0);
      check("arst_key", ifc.dp_key, 0);
      repeat (2) @(negedge clk);
      n_rst = 1'b1;

      spurious = 1'b1;
      repeat (3) @(negedge clk);
      spurious = 1'b0;
      @(negedge clk);
      check("spur_busy", ifc.busy, 0);
      check("spur_key_req", ifc.key_req, 0);
      check("spur_in_ready", ifc.in_ready, 1);
      check("spur_state", ifc.dp_state, 0);
      check("spur_key", ifc.dp_key, 0);

      p = {$urandom, $urandom, $urandom, $urandom};
      send_block(aes_enc(p), p);
      wait_done();

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
